// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem, and
// feeds IF/ID through a 2-entry skid buffer that absorbs responses during stalls.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr
);

  logic [XLEN-1:0]          r_pc;
  logic                     r_inflight;
  logic [XLEN-1:0]          r_inflight_pc;
  logic [1:0]               r_count;
  logic [1:0][XLEN-1:0]     r_buf_pc;
  logic [1:0][XLEN-1:0]     r_buf_instr;
  logic                     r_id_valid;
  logic [XLEN-1:0]          r_id_pc;
  logic [XLEN-1:0]          r_id_instr;

  logic                     w_req;
  logic [XLEN-1:0]          w_addr;
  logic [XLEN-1:0]          w_pc_n;
  logic [1:0]               w_occ;
  logic [1:0]               w_slot;
  logic                     w_take_incoming;
  logic [1:0]               w_count_n;
  logic [1:0][XLEN-1:0]     w_buf_pc_n;
  logic [1:0][XLEN-1:0]     w_buf_instr_n;
  logic                     w_id_valid_n;
  logic [XLEN-1:0]          w_id_pc_n;
  logic [XLEN-1:0]          w_id_instr_n;

  // Buffered entries plus the response still on its way; bounded by 2.
  assign w_occ = r_count + {1'b0, r_inflight};

  always_comb begin
    w_req           = 1'b0;
    w_addr          = r_pc;
    w_pc_n          = r_pc;
    w_slot          = r_count;
    w_take_incoming = 1'b0;
    w_count_n       = r_count;
    w_buf_pc_n      = r_buf_pc;
    w_buf_instr_n   = r_buf_instr;
    w_id_valid_n    = r_id_valid;
    w_id_pc_n       = r_id_pc;
    w_id_instr_n    = r_id_instr;

    if (redirect) begin
      w_req        = 1'b1;
      w_addr       = redirect_pc & ~XLEN'(3);
      w_pc_n       = w_addr + XLEN'(4);
      w_count_n    = 2'd0;
      w_id_valid_n = 1'b0;
      w_id_pc_n    = '0;
      w_id_instr_n = NOP_INSTR;
    end else begin
      w_req = !stall || (w_occ < 2'd2);
      if (w_req) begin
        w_pc_n = r_pc + XLEN'(4);
      end

      if (!stall) begin
        if (r_count != 2'd0) begin
          w_id_valid_n     = 1'b1;
          w_id_pc_n        = r_buf_pc[0];
          w_id_instr_n     = r_buf_instr[0];
          w_buf_pc_n[0]    = r_buf_pc[1];
          w_buf_instr_n[0] = r_buf_instr[1];
          w_slot           = r_count - 2'd1;
        end else if (r_inflight) begin
          w_take_incoming = 1'b1;
          w_id_valid_n    = 1'b1;
          w_id_pc_n       = r_inflight_pc;
          w_id_instr_n    = imem_rdata;
        end else begin
          w_id_valid_n = 1'b0;
          w_id_pc_n    = '0;
          w_id_instr_n = NOP_INSTR;
        end
      end

      // A response that IF/ID did not take goes to the tail, keeping program order.
      w_count_n = w_slot;
      if (r_inflight && !w_take_incoming && (w_slot != 2'd2)) begin
        w_buf_pc_n[w_slot[0]]    = r_inflight_pc;
        w_buf_instr_n[w_slot[0]] = imem_rdata;
        w_count_n                = w_slot + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_inflight  <= 1'b0;
      r_count     <= 2'd0;
      r_id_valid  <= 1'b0;
      r_id_pc     <= '0;
      r_id_instr  <= NOP_INSTR;
    end else begin
      r_pc        <= w_pc_n;
      r_inflight  <= w_req;
      r_count     <= w_count_n;
      r_id_valid  <= w_id_valid_n;
      r_id_pc     <= w_id_pc_n;
      r_id_instr  <= w_id_instr_n;
    end
  end

  // Payload only; its meaning is qualified by r_inflight / r_count.
  always_ff @(posedge clock) begin
    r_inflight_pc <= w_addr;
    r_buf_pc      <= w_buf_pc_n;
    r_buf_instr   <= w_buf_instr_n;
  end

  overflow_chk: assert property (@(posedge clock) disable iff (!reset)
    !(stall && !redirect && r_inflight && (r_count == 2'd2)));

  assign imem_req    = w_req;
  assign imem_addr   = w_addr;
  assign if_id_valid = r_id_valid;
  assign if_id_pc    = r_id_pc;
  assign if_id_instr = r_id_instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: imem model returns addr>>2; a queue-based scoreboard
// checks every instruction that IF/ID newly accepts, plus directed timing checks.
module tb_fetch_stage;

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            stall = 1'b0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata = '0;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_instr;

  fetch_stage dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
  );

  always #5 clock = ~clock;

  // 1-cycle synchronous instruction memory
  always @(posedge clock) begin
    if (imem_req) imem_rdata <= imem_addr >> 2;
  end

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  bit   loaded  = 1'b0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // IF/ID loads at an edge only when neither stalled nor redirected.
  always @(posedge clock) loaded <= reset && !stall && !redirect;

  always @(negedge clock) begin
    if (mon_en && loaded) begin
      if (if_id_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr_pc", if_id_pc, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_pc", if_id_pc, e.pc);
          check("sb_instr", if_id_instr, e.instr);
        end
      end else begin
        check("sb_bubble_instr", if_id_instr, 32'h0000_0013);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    check("rst_valid", {31'b0, if_id_valid}, 32'd0);
    check("rst_pc", if_id_pc, 32'd0);
    check("rst_instr", if_id_instr, 32'h0000_0013);
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
      #1;
    end
    check({name, "_drained"}, exp_q.size(), 32'd0);
    mon_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: plain fetch after reset
    do_reset();
    for (int k = 0; k < 8; k++) push_exp(32'(4 * k), 32'(k));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      check("s1_addr", imem_addr, 32'(4 * k));
      check("s1_req", {31'b0, imem_req}, 32'd1);
      check("s1_valid", {31'b0, if_id_valid}, (k >= 2) ? 32'd1 : 32'd0);
    end
    wait_drain("s1");

    // Scenario 2: stall held for 3 cycles
    do_reset();
    for (int k = 0; k < 10; k++) push_exp(32'(4 * k), 32'(k));
    repeat (3) @(negedge clock);
    stall = 1'b1;
    #1;
    check("s2_req_c3", {31'b0, imem_req}, 32'd1);
    check("s2_addr_c3", imem_addr, 32'h0000_000C);
    for (int k = 4; k <= 5; k++) begin
      @(negedge clock);
      #1;
      check("s2_req_drop", {31'b0, imem_req}, 32'd0);
      check("s2_frozen_pc", if_id_pc, 32'h0000_0004);
    end
    @(negedge clock);
    check("s2_frozen_pc_c6", if_id_pc, 32'h0000_0004);
    check("s2_frozen_vld", {31'b0, if_id_valid}, 32'd1);
    stall = 1'b0;
    wait_drain("s2");

    // Scenario 3: redirect while stalled with a full buffer
    do_reset();
    push_exp(32'h0, 32'h0);
    push_exp(32'h4, 32'h1);
    push_exp(32'h100, 32'h40);
    push_exp(32'h104, 32'h41);
    push_exp(32'h108, 32'h42);
    repeat (3) @(negedge clock);
    stall = 1'b1;
    @(negedge clock);
    #1;
    check("s3_req_full", {31'b0, imem_req}, 32'd0);
    @(negedge clock);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    check("s3_redir_req", {31'b0, imem_req}, 32'd1);
    check("s3_redir_addr", imem_addr, 32'h0000_0100);
    @(negedge clock);
    check("s3_bubble_vld", {31'b0, if_id_valid}, 32'd0);
    check("s3_bubble_instr", if_id_instr, 32'h0000_0013);
    check("s3_bubble_pc", if_id_pc, 32'd0);
    redirect = 1'b0;
    stall = 1'b0;
    wait_drain("s3");

    // Scenario 4: back-to-back redirects, second one misaligned
    do_reset();
    push_exp(32'h0, 32'h0);
    push_exp(32'h4, 32'h1);
    push_exp(32'h8, 32'h2);
    push_exp(32'h80, 32'h20);
    push_exp(32'h84, 32'h21);
    push_exp(32'h88, 32'h22);
    repeat (4) @(negedge clock);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    #1;
    check("s4_addr_40", imem_addr, 32'h0000_0040);
    @(negedge clock);
    redirect_pc = 32'h0000_0083;
    #1;
    check("s4_addr_80", imem_addr, 32'h0000_0080);
    check("s4_vld_c5", {31'b0, if_id_valid}, 32'd0);
    @(negedge clock);
    redirect = 1'b0;
    check("s4_vld_c6", {31'b0, if_id_valid}, 32'd0);
    wait_drain("s4");

    // Scenario 5: async reset mid-cycle during a stall with a full buffer
    do_reset();
    push_exp(32'h0, 32'h0);
    push_exp(32'h4, 32'h1);
    repeat (3) @(negedge clock);
    stall = 1'b1;
    repeat (2) @(negedge clock);
    #2;
    check("s5_pre_vld", {31'b0, if_id_valid}, 32'd1);
    check("s5_pre_pc", if_id_pc, 32'h0000_0004);
    check("s5_pre_empty", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("s5_async_vld", {31'b0, if_id_valid}, 32'd0);
    check("s5_async_pc", if_id_pc, 32'd0);
    check("s5_async_instr", if_id_instr, 32'h0000_0013);
    check("s5_async_addr", imem_addr, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    stall = 1'b0;
    mon_en = 1'b1;
    push_exp(32'h0, 32'h0);
    push_exp(32'h4, 32'h1);
    push_exp(32'h8, 32'h2);
    #1;
    check("s5_restart_addr", imem_addr, 32'd0);
    check("s5_restart_req", {31'b0, imem_req}, 32'd1);
    wait_drain("s5");

    // Scenario 6: PC wraps past the top of the address space
    do_reset();
    push_exp(32'h0, 32'h0);
    push_exp(32'hFFFF_FFFC, 32'h3FFF_FFFF);
    push_exp(32'h0, 32'h0);
    push_exp(32'h4, 32'h1);
    repeat (2) @(negedge clock);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    check("s6_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clock);
    redirect = 1'b0;
    #1;
    check("s6_wrap_addr", imem_addr, 32'h0000_0000);
    wait_drain("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline. Feeds the decode stage through the IF/ID pipeline register.
- Owns the PC and issues requests to a 1-cycle-latency synchronous instruction memory.
- Absorbs in-flight responses during hazard stalls in a 2-entry skid buffer, so decode never loses or duplicates an instruction.
- Squashes wrong-path instructions on a branch/jump redirect.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on if_id_instr when invalid.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  from the hazard unit; holds the IF/ID register and blocks consumption.
- redirect  in  1  branch/jump taken, resolved downstream.
- redirect_pc  in  XLEN  target address, valid when redirect=1.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_rdata  in  XLEN  instruction for the request issued in the previous cycle.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  XLEN  PC of the IF/ID instruction.
- if_id_instr  out  XLEN  instruction; NOP_INSTR when if_id_valid=0.

Behaviour:
- Reset (async, active-low) forces:
  - pc_q=RESET_PC; inflight=0; buffer empty (count=0).
  - if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR.
  - Outputs take these values immediately on assertion, including mid-operation. Any in-flight response is discarded.
- Memory timing:
  - A request issued in cycle N returns imem_rdata during cycle N+1.
  - inflight/inflight_pc record whether cycle N issued a request, and its address.
- Request rule:
  - When redirect=0: imem_req = (!stall) || (count + inflight < 2).
  - When issued: imem_addr=pc_q, and pc_q <= pc_q+4 (wraps modulo 2^XLEN).
  - When not issued: imem_addr=pc_q, and pc_q holds.
- Consume rule (redirect=0, stall=0):
  - IF/ID loads the buffer head if count>0, else the incoming response if inflight=1, else a bubble.
  - An incoming response that is not consumed is appended to the buffer tail.
- Stall (redirect=0, stall=1):
  - IF/ID holds all three outputs unchanged.
  - An incoming response is appended to the buffer.
  - The request rule guarantees count never exceeds 2. Overflow is a design error; flag it with a simulation assertion.
- Redirect (has priority over stall):
  - imem_req=1 and imem_addr=redirect_pc in the same cycle; pc_q <= redirect_pc+4.
  - Buffer cleared; the response arriving this cycle is dropped.
  - IF/ID loads a bubble (valid=0, pc=0, instr=NOP_INSTR).
  - The target instruction reaches IF/ID two edges later if not stalled.
- Latency:
  - Request in cycle N means if_id_valid=1 from cycle N+2 when unstalled.
  - Steady-state throughput is 1 instruction/cycle.
- Ordering: instructions reach IF/ID in strict program order. Buffer entries carry their pc.
- redirect_pc[1:0] is ignored and treated as 00.

Test Plan:
- Reset release, imem returns addr>>2 as data, no stall:
  - imem_addr sequence 0,4,8,...
  - if_id_valid rises on the 2nd edge after release, with pc=0, instr=0; next cycle pc=4, instr=1; one instruction per cycle.
- Steady fetch, then stall held for 3 cycles:
  - IF/ID frozen at its current pc.
  - imem_req drops once count+inflight=2.
  - After release, IF/ID shows the next pcs consecutively with no gaps or duplicates.
- redirect=1 with redirect_pc=0x100 while stall=1 and the buffer holds 2 entries:
  - Next edge: if_id_valid=0, instr=0x13.
  - Edge after: if_id_valid=1, pc=0x100, then 0x104.
  - No stale instruction from the old path appears.
- Back-to-back redirects to 0x40, then 0x80:
  - Only pc=0x80 reaches IF/ID valid; 0x40 is never valid.
- Async reset asserted mid-cycle during a stall with a full buffer:
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC.
- PC wrap: redirect_pc=0xFFFF_FFFC:
  - IF/ID sequence is 0xFFFF_FFFC, then 0x0000_0000.
